// File: rtl/lcd_text_buffer.sv
// Score-to-ASCII frame composer for a 2x16 character LCD, double buffered with a ready/ack flag.
// Optional define LCD_TB_ZERO_SUPPRESS_EN blanks leading zero digits of the score.
module lcd_text_buffer #(
  parameter int          SCORE_W = 14,
  parameter logic [7:0]  BLANK   = 8'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_req,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [1:0]         mode,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_data,
  output logic               busy,
  output logic               upd_done,
  output logic               frame_rdy,
  input  logic               frame_ack
);

  // Handshake: upd_req is accepted on any cycle it is high; frame_rdy stays high
  // from upd_done until a frame_ack arrives in a cycle other than the upd_done cycle.

  typedef enum logic [1:0] {IDLE, CONV, FILL, DONE} state_t;

  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(9999);
  localparam logic [127:0] L1_TITLE = "CHICKEN CHACHA  ";
  localparam logic [127:0] L1_PLAY  = "  PLAYING...    ";
  localparam logic [127:0] L1_OVER  = "   GAME OVER    ";
  localparam logic [127:0] L1_PAUSE = "     PAUSE      ";
  localparam logic [63:0]  L2_TEXT  = {"SCORE: ", BLANK};

  state_t               state, state_n;
  state_t               dbg_state;
  logic [SCORE_W-1:0]   req_score;
  logic [1:0]           req_mode;
  logic                 pend;
  logic [SCORE_W-1:0]   sh;
  logic [15:0]          bcd;
  logic [15:0]          bcd_adj;
  logic [1:0]           work_mode;
  logic [5:0]           cnt;
  logic                 front;
  logic [7:0]           mem [64];
  logic [7:0]           fill_char;
  logic [127:0]         line1_txt;
  logic [7:0]           dig_char [4];
  logic [3:0]           dig_blank;

  assign dbg_state = state;
  assign busy      = (state != IDLE);
  assign upd_done  = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (upd_req) state_n = CONV;
      CONV: if (cnt == 6'(SCORE_W)) state_n = FILL;
      FILL: if (cnt == 6'd31) state_n = DONE;
      DONE: state_n = (pend || upd_req) ? CONV : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Double-dabble add-3 correction applied before every shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    line1_txt = L1_TITLE;
    case (work_mode)
      2'd1:    line1_txt = L1_PLAY;
      2'd2:    line1_txt = L1_OVER;
      2'd3:    line1_txt = L1_PAUSE;
      default: line1_txt = L1_TITLE;
    endcase
  end

  always_comb begin
    dig_blank = 4'b0000;
`ifdef LCD_TB_ZERO_SUPPRESS_EN
    dig_blank[3] = (bcd[15:12] == 4'd0);
    dig_blank[2] = dig_blank[3] && (bcd[11:8] == 4'd0);
    dig_blank[1] = dig_blank[2] && (bcd[7:4] == 4'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      dig_char[i] = dig_blank[i] ? BLANK : {4'h3, bcd[4*i +: 4]};
    end
  end

  always_comb begin
    fill_char = BLANK;
    if (!cnt[4]) begin
      fill_char = line1_txt[{~cnt[3:0], 3'b000} +: 8];
    end else begin
      case (cnt[4:0])
        5'd23:   fill_char = dig_char[3];
        5'd24:   fill_char = dig_char[2];
        5'd25:   fill_char = dig_char[1];
        5'd26:   fill_char = dig_char[0];
        default: if (cnt[4:0] < 5'd23) fill_char = L2_TEXT[{~cnt[2:0], 3'b000} +: 8];
      endcase
    end
  end

  // Request capture: the newest upd_req always wins; pend marks one waiting behind a busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_score <= '0;
      req_mode  <= 2'd0;
      pend      <= 1'b0;
    end else begin
      if (upd_req) begin
        req_score <= (score_in > MAX_SCORE) ? MAX_SCORE : score_in;
        req_mode  <= mode;
      end
      if (state == DONE)                 pend <= 1'b0;
      else if (upd_req && state != IDLE) pend <= 1'b1;
    end
  end

  // First CONV cycle loads the captured request, then SCORE_W shifts follow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 6'd0;
      sh        <= '0;
      bcd       <= 16'd0;
      work_mode <= 2'd0;
    end else begin
      cnt <= (state_n != state) ? 6'd0 : cnt + 6'd1;
      if (state == CONV) begin
        if (cnt == 6'd0) begin
          sh        <= req_score;
          bcd       <= 16'd0;
          work_mode <= req_mode;
        end else begin
          {bcd, sh} <= {bcd_adj[14:0], sh, 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front   <= 1'b0;
      rd_data <= BLANK;
      for (int i = 0; i < 64; i++) mem[i] <= BLANK;
    end else begin
      if (state == FILL) mem[{~front, cnt[4:0]}] <= fill_char;
      if (state == FILL && state_n == DONE) front <= ~front;
      rd_data <= mem[{front, rd_addr}];
    end
  end

  // Set has priority over ack while entering or sitting in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 frame_rdy <= 1'b0;
    else if (state_n == DONE || state == DONE) frame_rdy <= 1'b1;
    else if (frame_ack)                       frame_rdy <= 1'b0;
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: frame vector table, read scoreboard, and handshake/reset sequences.
module tb_lcd_text_buffer;

  localparam int SCORE_W = 14;

  logic               clk;
  logic               rst;
  logic               upd_req;
  logic [SCORE_W-1:0] score_in;
  logic [1:0]         mode;
  logic [4:0]         rd_addr;
  logic [7:0]         rd_data;
  logic               busy;
  logic               upd_done;
  logic               frame_rdy;
  logic               frame_ack;

  int total;
  int bad;
  logic [7:0] exp_q[$];

  logic [127:0] l1_txt [4];
  logic [55:0]  score_txt;

  typedef struct {
    int unsigned score;
    logic [1:0]  mode;
    logic [31:0] dg;
  } vec_t;
  vec_t vecs [9];

  lcd_text_buffer #(.SCORE_W(SCORE_W), .BLANK(8'h20)) dut (
    .clk(clk), .rst(rst), .upd_req(upd_req), .score_in(score_in), .mode(mode),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .upd_done(upd_done),
    .frame_rdy(frame_rdy), .frame_ack(frame_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int a, input logic [1:0] m, input logic [31:0] dg);
    if (a < 16)      return l1_txt[m][8*(15-a) +: 8];
    else if (a < 23) return score_txt[8*(22-a) +: 8];
    else if (a < 27) return dg[8*(26-a) +: 8];
    else             return 8'h20;
  endfunction

  task automatic read_chk(input int a, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    rd_addr = 5'(a);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, e});
  endtask

  task automatic check_frame(input logic [1:0] m, input logic [31:0] dg);
    for (int a = 0; a < 32; a++) read_chk(a, exp_char(a, m, dg));
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic req(input int unsigned s, input logic [1:0] m);
    upd_req  = 1'b1;
    score_in = SCORE_W'(s);
    mode     = m;
    @(posedge clk);
    @(negedge clk);
    upd_req  = 1'b0;
    score_in = SCORE_W'($urandom_range(0, 16383));
    mode     = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int n);
    bit found;
    n = 0;
    found = 0;
    while (n < 200 && !found) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (upd_done) found = 1;
    end
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    int n;
    int dones;
    int extra;
    bit busy_drop;
    bit seen;
    total = 0;
    bad = 0;
    l1_txt[0] = "CHICKEN CHACHA  ";
    l1_txt[1] = "  PLAYING...    ";
    l1_txt[2] = "   GAME OVER    ";
    l1_txt[3] = "     PAUSE      ";
    score_txt = "SCORE: ";
`ifdef LCD_TB_ZERO_SUPPRESS_EN
    vecs[0] = '{1234,  2'd0, "1234"};
    vecs[1] = '{12000, 2'd2, "9999"};
    vecs[2] = '{0,     2'd3, "   0"};
    vecs[3] = '{42,    2'd1, "  42"};
    vecs[4] = '{9999,  2'd0, "9999"};
    vecs[5] = '{10000, 2'd1, "9999"};
    vecs[6] = '{16383, 2'd3, "9999"};
    vecs[7] = '{305,   2'd2, " 305"};
    vecs[8] = '{7,     2'd0, "   7"};
`else
    vecs[0] = '{1234,  2'd0, "1234"};
    vecs[1] = '{12000, 2'd2, "9999"};
    vecs[2] = '{0,     2'd3, "0000"};
    vecs[3] = '{42,    2'd1, "0042"};
    vecs[4] = '{9999,  2'd0, "9999"};
    vecs[5] = '{10000, 2'd1, "9999"};
    vecs[6] = '{16383, 2'd3, "9999"};
    vecs[7] = '{305,   2'd2, "0305"};
    vecs[8] = '{7,     2'd0, "0007"};
`endif

    rst = 1'b0;
    upd_req = 1'b0;
    score_in = '0;
    mode = 2'd0;
    rd_addr = 5'd0;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdy", {31'd0, frame_rdy}, 32'd0);
    check("reset_rd_data", {24'd0, rd_data}, 32'h20);
    rst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 32; a++) read_chk(a, 8'h20);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_rdy", {31'd0, frame_rdy}, 32'd0);

    // Frame table: latency, content and handshake for each score/mode pair
    for (int v = 0; v < 9; v++) begin
      req(vecs[v].score, vecs[v].mode);
      check("busy_after_req", {31'd0, busy}, 32'd1);
      wait_done(n);
      check("latency", n, 47);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      check("rdy_with_done", {31'd0, frame_rdy}, 32'd1);
      check_frame(vecs[v].mode, vecs[v].dg);
      check("rdy_before_ack", {31'd0, frame_rdy}, 32'd1);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
      ack_pulse();
      check("rdy_after_ack", {31'd0, frame_rdy}, 32'd0);
    end

    // Read coherency on the units digit: '7' from the last frame until after DONE, then '4'
    rd_addr = 5'd26;
    req(1234, 2'd0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("coherency_c%0d", c), {24'd0, rd_data}, seen ? 32'h34 : 32'h37);
      if (upd_done) seen = 1;
    end
    check("coherency_done_seen", {31'd0, seen}, 32'd1);
    ack_pulse();

    // Pending requests: 7 is overwritten by 8, exactly two frames, busy held throughout
    req(5, 2'd1);
    repeat (3) @(negedge clk);
    req(7, 2'd1);
    repeat (2) @(negedge clk);
    req(8, 2'd1);
    dones = 0;
    busy_drop = 0;
    for (int c = 0; c < 300 && dones < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) busy_drop = 1;
      if (upd_done) dones++;
    end
    check("pend_dones", dones, 2);
    check("pend_busy_drop", {31'd0, busy_drop}, 32'd0);
    extra = 0;
    repeat (70) begin
      @(negedge clk);
      if (upd_done) extra++;
    end
    check("pend_extra_done", extra, 0);
    check("pend_busy_end", {31'd0, busy}, 32'd0);
`ifdef LCD_TB_ZERO_SUPPRESS_EN
    check_frame(2'd1, "   8");
`else
    check_frame(2'd1, "0008");
`endif

    // Reset in the middle of FILL with a request pending behind it
    req(300, 2'd2);
    repeat (25) @(negedge clk);
    req(400, 2'd3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, upd_done}, 32'd0);
    check("midrst_rdy", {31'd0, frame_rdy}, 32'd0);
    check("midrst_rd_data", {24'd0, rd_data}, 32'h20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 32; a++) read_chk(a, 8'h20);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (upd_done) extra++;
    end
    check("midrst_no_done", extra, 0);

    // Ack coincident with upd_done: set wins
    req(1, 2'd0);
    wait_done(n);
    check("coinc_latency", n, 47);
    ack_pulse();
    check("coinc_rdy", {31'd0, frame_rdy}, 32'd1);
    ack_pulse();
    check("ack_clears", {31'd0, frame_rdy}, 32'd0);
    ack_pulse();
    check("ack_ignored", {31'd0, frame_rdy}, 32'd0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Upstream content stage for the 2x16 character LCD driver.
- Converts the game score to decimal ASCII and composes a 32-character frame: line 1 is a status message, line 2 is the score.
- Holds the frame in a double buffer and serves a synchronous read port indexed by the LCD driver.
- Raises a frame-ready flag with a ready/ack handshake so the driver refreshes only when the content has changed.

Parameters:
SCORE_W, 14, width of the binary score input
BLANK, 8'h20, ASCII code used for empty positions

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
upd_req  in  1  single-cycle pulse; samples score_in and mode
score_in  in  SCORE_W  binary score
mode  in  2  0=title, 1=play, 2=game over, 3=pause
rd_addr  in  5  character index; 0-15 = line 1, 16-31 = line 2
rd_data  out  8  ASCII of front-buffer character at rd_addr
busy  out  1  conversion or fill in progress
upd_done  out  1  single-cycle pulse when the new frame becomes visible
frame_rdy  out  1  level; a new frame is pending for the LCD driver
frame_ack  in  1  single-cycle pulse from the LCD driver: frame consumed

Behaviour:
- Reset (rst=0, async):
  - State IDLE; busy=0, upd_done=0, frame_rdy=0.
  - All 64 buffer bytes = BLANK; rd_data=BLANK.
  - Pending request cleared.
- Read port:
  - rd_data is registered, 1-cycle latency, and always reads the front buffer.
  - It never shows a partially written frame.
- FSM IDLE -> CONV -> FILL -> DONE -> IDLE.
- IDLE:
  - upd_req=1 latches score and mode, then goes to CONV.
  - busy=1 from the next cycle.
- CONV:
  - Sequential double-dabble, one shift per cycle, exactly SCORE_W cycles.
  - Produces 4 BCD digits.
  - Score > 9999 saturates to 9999; the clamp is applied on capture.
- FILL:
  - 32 cycles; writes back-buffer address 0..31, one per cycle.
  - Line 1 text by mode:
    - 0: "CHICKEN CHACHA  "
    - 1: "  PLAYING...    "
    - 2: "   GAME OVER    "
    - 3: "     PAUSE      "
  - Line 2: "SCORE: " at 16-22, thousands..units at 23-26 (ASCII 8'h30+digit), BLANK at 27-31.
- DONE:
  - The front/back buffer swap happens on the edge entering DONE.
  - upd_done=1 for this one cycle; frame_rdy set.
  - busy stays 1 in DONE and drops on return to IDLE.
- Latency: upd_done rises SCORE_W+33 cycles after the edge that sampled upd_req (47 at default).
- upd_req while busy:
  - Stored as a one-deep pending request; the newest score/mode overwrites older ones.
  - From DONE, a pending request goes to CONV directly (busy stays 1); otherwise to IDLE.
- frame_rdy:
  - Cleared by frame_ack.
  - If upd_done and frame_ack occur in the same cycle, set wins (frame_rdy=1).
  - frame_ack while frame_rdy=0 is ignored.
- mode and score_in are don't-care except when upd_req=1.
- Reset mid-operation: the conversion is aborted, the pending request is lost, and both buffers return to blanks.

Optional Feature:
- Macro LCD_TB_ZERO_SUPPRESS_EN.
- When defined:
  - Leading zero digits of the score are written as BLANK.
  - The units digit is always printed (score 0 -> "   0", 42 -> "  42").
- When undefined: all 4 digits are printed with leading zeros ("0042").

Test Plan:
1. Release reset, read addresses 0-31 -> every rd_data=8'h20; busy=0, frame_rdy=0.
2. upd_req with score=1234, mode=0 -> upd_done exactly 47 cycles later.
   - Addresses 0-13 read "CHICKEN CHACHA", 23-26 read 8'h31,32,33,34.
   - frame_rdy=1 until frame_ack, then 0.
3. score=12000, mode=2 -> digits read "9999"; line 1 reads "   GAME OVER    ".
4. Pending request:
   - Issue score=5, mode=1; during CONV issue score=7 then score=8.
   - Expect two upd_done pulses.
   - The second frame shows "0008" (or "   8" with LCD_TB_ZERO_SUPPRESS_EN); busy never drops between them.
5. Read coherency: read address 26 every cycle during FILL -> the old value holds until after DONE, then the new value appears.
6. Reset and handshake edges:
   - Assert rst=0 mid-FILL -> all outputs at reset values immediately.
   - Separately, frame_ack coincident with upd_done -> frame_rdy=1.
